// File: rtl/pwm_seq_ctrl_if.sv
// Bus bundle for the PWM step sequencer: step-table writes, run configuration,
// run control, and the values fed to the downstream PWM core.
interface pwm_seq_ctrl_if;
  logic       cfg_we;
  logic [2:0] cfg_addr;
  logic [7:0] cfg_wdata;
  logic [2:0] cfg_bits;
  logic [7:0] cfg_hold;
  logic [2:0] cfg_last;
  logic       cfg_loop;
  logic       start;
  logic       stop;
  logic [7:0] duty_out;
  logic [2:0] bits_out;
  logic [2:0] step_idx;
  logic       busy;
  logic       done;

  modport master (
    output cfg_we, cfg_addr, cfg_wdata, cfg_bits, cfg_hold, cfg_last, cfg_loop,
    output start, stop,
    input  duty_out, bits_out, step_idx, busy, done
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, cfg_bits, cfg_hold, cfg_last, cfg_loop,
    input  start, stop,
    output duty_out, bits_out, step_idx, busy, done
  );
endinterface

// File: rtl/pwm_seq_ctrl.sv
// PWM step sequencer: walks an 8-entry duty table, holding each entry for
// hold_eff PWM periods of 2**bits+1 cycles, one-shot or looping.
module pwm_seq_ctrl (
  input  logic           clk,
  input  logic           rst_n,
  pwm_seq_ctrl_if.slave  bus
);
  typedef enum logic {IDLE, RUN} state_t;

  state_t     state, state_nx;
  logic [7:0] table_q [8];

  // Shadow copies of the run configuration, taken on an accepted start
  logic [2:0] bits_r, last_r;
  logic [7:0] hold_r;
  logic       loop_r;
  logic       latch;

  logic [8:0] pcnt, pcnt_nx;
  logic [7:0] hcnt, hcnt_nx;
  logic [7:0] duty_q, duty_nx;
  logic [2:0] bits_q, bits_nx;
  logic [2:0] idx_q, idx_nx;
  logic       busy_q, busy_nx;
  logic       done_q, done_nx;

  // Period top is 2**bits_r evaluated at 9 bits so bits_r=7 gives 128 without overflow
  logic [8:0] top;
  logic [7:0] hold_m1;
  logic       period_end, step_end;

  // Derived period/step boundaries; hold of 0 behaves as 1
  always_comb begin
    top        = 9'd1 << bits_r;
    hold_m1    = (hold_r == 8'd0) ? 8'd0 : hold_r - 8'd1;
    period_end = (pcnt == top);
    step_end   = period_end && (hcnt == hold_m1);
  end

  // Next-state and next-output logic
  always_comb begin
    state_nx = state;
    pcnt_nx  = pcnt;
    hcnt_nx  = hcnt;
    duty_nx  = duty_q;
    bits_nx  = bits_q;
    idx_nx   = idx_q;
    busy_nx  = busy_q;
    done_nx  = 1'b0;
    latch    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          latch    = 1'b1;
          state_nx = RUN;
          duty_nx  = table_q[0];
          idx_nx   = '0;
          bits_nx  = bus.cfg_bits;
          pcnt_nx  = '0;
          hcnt_nx  = '0;
          busy_nx  = 1'b1;
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_nx = IDLE;
          duty_nx  = '0;
          idx_nx   = '0;
          busy_nx  = 1'b0;
          pcnt_nx  = '0;
          hcnt_nx  = '0;
        end else if (period_end) begin
          pcnt_nx = '0;
          if (step_end) begin
            hcnt_nx = '0;
            if (idx_q < last_r) begin
              idx_nx  = idx_q + 3'd1;
              duty_nx = table_q[idx_q + 3'd1];
            end else if (loop_r) begin
              idx_nx  = '0;
              duty_nx = table_q[0];
            end else begin
              state_nx = IDLE;
              duty_nx  = '0;
              busy_nx  = 1'b0;
              done_nx  = 1'b1;
            end
          end else begin
            hcnt_nx = hcnt + 8'd1;
          end
        end else begin
          pcnt_nx = pcnt + 9'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Counters, shadow configuration and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcnt   <= '0;
      hcnt   <= '0;
      duty_q <= '0;
      bits_q <= '0;
      idx_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      bits_r <= '0;
      last_r <= '0;
      hold_r <= '0;
      loop_r <= 1'b0;
    end else begin
      pcnt   <= pcnt_nx;
      hcnt   <= hcnt_nx;
      duty_q <= duty_nx;
      bits_q <= bits_nx;
      idx_q  <= idx_nx;
      busy_q <= busy_nx;
      done_q <= done_nx;
      if (latch) begin
        bits_r <= bus.cfg_bits;
        last_r <= bus.cfg_last;
        hold_r <= bus.cfg_hold;
        loop_r <= bus.cfg_loop;
      end
    end
  end

  // Step table; loads read the pre-edge contents so a write lands at the next load
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 8; i++) table_q[i] <= '0;
    end else if (bus.cfg_we) begin
      table_q[bus.cfg_addr] <= bus.cfg_wdata;
    end
  end

  assign bus.duty_out = duty_q;
  assign bus.bits_out = bits_q;
  assign bus.step_idx = idx_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
endmodule

// File: tb/tb_pwm_seq_ctrl.sv
// Self-checking bench for pwm_seq_ctrl: directed scenarios plus random traffic
// against a step-length reference model.
module tb_pwm_seq_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pwm_seq_ctrl_if bus();
  pwm_seq_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int total = 0;
  int bad   = 0;

  // Reference model: each step simply lasts (2**bits+1)*max(hold,1) cycles
  logic [7:0] m_tbl [8];
  logic       m_busy, m_done, m_loop;
  logic [7:0] m_duty;
  logic [2:0] m_bits, m_idx, m_last;
  bit         m_idx_known;
  int         m_cnt, m_len;

  int edge_no;
  int done_edge;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d at edge %0d", tag, got, exp, edge_no);
    end
  endtask

  task automatic model_edge();
    int hold_eff;
    m_done = 1'b0;
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) m_tbl[i] = 8'd0;
      m_busy = 1'b0; m_duty = 8'd0; m_bits = 3'd0; m_idx = 3'd0;
      m_idx_known = 1'b1; m_cnt = 0; m_len = 1; m_last = 3'd0; m_loop = 1'b0;
    end else begin
      if (!m_busy) begin
        if (bus.start && !bus.stop) begin
          hold_eff = (bus.cfg_hold == 8'd0) ? 1 : int'(bus.cfg_hold);
          m_busy = 1'b1; m_idx = 3'd0; m_duty = m_tbl[0]; m_bits = bus.cfg_bits;
          m_last = bus.cfg_last; m_loop = bus.cfg_loop;
          m_len = ((1 << bus.cfg_bits) + 1) * hold_eff;
          m_cnt = 0; m_idx_known = 1'b1;
        end
      end else if (bus.stop) begin
        m_busy = 1'b0; m_duty = 8'd0; m_idx = 3'd0; m_idx_known = 1'b1;
      end else if (m_cnt == m_len - 1) begin
        m_cnt = 0;
        if (m_idx < m_last) begin
          m_idx = m_idx + 3'd1;
          m_duty = m_tbl[m_idx];
        end else if (m_loop) begin
          m_idx = 3'd0; m_duty = m_tbl[0];
        end else begin
          m_busy = 1'b0; m_duty = 8'd0; m_done = 1'b1; m_idx_known = 1'b0;
        end
      end else begin
        m_cnt++;
      end
      if (bus.cfg_we) m_tbl[bus.cfg_addr] = bus.cfg_wdata;
    end
  endtask

  // One clock: advance model, clock DUT, compare, then drop single-cycle strobes
  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    edge_no++;
    if (bus.done === 1'b1 && done_edge < 0) done_edge = edge_no;
    chk("duty", bus.duty_out, m_duty);
    chk("bits", {5'd0, bus.bits_out}, {5'd0, m_bits});
    chk("busy", {7'd0, bus.busy}, {7'd0, m_busy});
    chk("done", {7'd0, bus.done}, {7'd0, m_done});
    if (m_idx_known) chk("idx", {5'd0, bus.step_idx}, {5'd0, m_idx});
    bus.start  = 1'b0;
    bus.stop   = 1'b0;
    bus.cfg_we = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    bus.cfg_we = 1'b1; bus.cfg_addr = a; bus.cfg_wdata = d;
    cycle();
  endtask

  task automatic cfg(input logic [2:0] b, input logic [7:0] h, input logic [2:0] l, input logic lp);
    bus.cfg_bits = b; bus.cfg_hold = h; bus.cfg_last = l; bus.cfg_loop = lp;
  endtask

  // Assert start on the next edge, which becomes edge 0 of the run
  task automatic kick();
    bus.start = 1'b1;
    edge_no = -1;
    done_edge = -1;
    cycle();
  endtask

  initial begin
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_wdata = '0;
    bus.start = 1'b0; bus.stop = 1'b0;
    cfg(3'd0, 8'd0, 3'd0, 1'b0);
    edge_no = 0; done_edge = -1;

    // Reset state
    rst_n = 1'b0;
    run(2);
    rst_n = 1'b1;

    // One-shot three-step run
    wr(3'd0, 8'd10); wr(3'd1, 8'd20); wr(3'd2, 8'd30);
    cfg(3'd2, 8'd1, 3'd2, 1'b0);
    kick();
    chk("start_duty", bus.duty_out, 8'd10);
    run(4);
    chk("e4_duty", bus.duty_out, 8'd10);
    run(1);
    chk("e5_duty", bus.duty_out, 8'd20);
    run(5);
    chk("e10_duty", bus.duty_out, 8'd30);
    run(5);
    chk("e15_busy", {7'd0, bus.busy}, 8'd0);
    chk("done_edge", 8'(done_edge), 8'd15);
    run(3);
    chk("idle_bits", {5'd0, bus.bits_out}, 8'd2);

    // Looping run: step 0 reloads at edge 15, then stop
    cfg(3'd2, 8'd1, 3'd2, 1'b1);
    kick();
    run(15);
    chk("loop_duty", bus.duty_out, 8'd10);
    chk("loop_busy", {7'd0, bus.busy}, 8'd1);
    run(10);
    chk("loop_nodone", 8'(done_edge), 8'hFF);
    bus.stop = 1'b1;
    cycle();

    // Stop at edge 7
    cfg(3'd2, 8'd1, 3'd2, 1'b0);
    kick();
    run(6);
    bus.stop = 1'b1;
    cycle();
    chk("stop_busy", {7'd0, bus.busy}, 8'd0);
    chk("stop_idx", {5'd0, bus.step_idx}, 8'd0);
    run(10);
    chk("stop_nodone", 8'(done_edge), 8'hFF);

    // Start+stop together in IDLE, then start during RUN
    bus.start = 1'b1; bus.stop = 1'b1;
    cycle();
    chk("ss_idle", {7'd0, bus.busy}, 8'd0);
    kick();
    run(3);
    bus.start = 1'b1;
    cycle();
    run(11);
    chk("restart_ignored", 8'(done_edge), 8'd15);

    // Write to the active entry lands at its next load
    cfg(3'd2, 8'd1, 3'd2, 1'b1);
    kick();
    wr(3'd0, 8'd99);
    run(14);
    chk("late_write", bus.duty_out, 8'd99);
    bus.stop = 1'b1;
    cycle();

    // Minimum step: bits=0, hold=0 -> done at edge 2
    cfg(3'd0, 8'd0, 3'd0, 1'b0);
    kick();
    run(4);
    chk("min_done_edge", 8'(done_edge), 8'd2);

    // Widest step: bits=7, hold=2 -> 258 cycles
    cfg(3'd7, 8'd2, 3'd0, 1'b0);
    kick();
    run(262);
    chk("max_done_edge_lo", 8'(done_edge & 8'hFF), 8'(258 & 8'hFF));
    chk("max_done_edge_hi", 8'(done_edge >> 8), 8'd1);

    // Reset mid-run, then table reads zero
    cfg(3'd1, 8'd1, 3'd3, 1'b1);
    kick();
    run(5);
    rst_n = 1'b0;
    run(2);
    chk("rst_busy", {7'd0, bus.busy}, 8'd0);
    chk("rst_bits", {5'd0, bus.bits_out}, 8'd0);
    rst_n = 1'b1;
    kick();
    chk("rst_tbl0", bus.duty_out, 8'd0);
    run(8);
    chk("rst_tbl1", bus.duty_out, 8'd0);
    bus.stop = 1'b1;
    cycle();

    // Random traffic
    for (int i = 0; i < 8; i++) wr(3'(i), 8'($urandom_range(1, 255)));
    for (int i = 0; i < 500; i++) begin
      cfg(3'($urandom_range(0, 3)), 8'($urandom_range(0, 3)),
          3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      bus.start     = ($urandom_range(0, 19) == 0);
      bus.stop      = ($urandom_range(0, 59) == 0);
      bus.cfg_we    = ($urandom_range(0, 3) == 0);
      bus.cfg_addr  = 3'($urandom_range(0, 7));
      bus.cfg_wdata = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
      cycle();
      rst_n = 1'b1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pwm_seq_ctrl.md
PWM_SEQ_CTRL -- requirements
Module: pwm_seq_ctrl

Interface
REQ-001 SHALL have port clk, in, 1: rising-edge clock.
REQ-002 SHALL have port rst_n, in, 1: reset, synchronous, active-low; clock clk.
REQ-003 SHALL have port cfg_we, in, 1: step-table write strobe.
REQ-004 SHALL have port cfg_addr, in, 3: step-table write index (8 entries).
REQ-005 SHALL have port cfg_wdata, in, 8: duty value written to the table.
REQ-006 SHALL have port cfg_bits, in, 3: PWM resolution exponent, sampled on accepted start.
REQ-007 SHALL have port cfg_hold, in, 8: PWM periods per step, sampled on accepted start.
REQ-008 SHALL have port cfg_last, in, 3: index of the final step, sampled on accepted start.
REQ-009 SHALL have port cfg_loop, in, 1: 1 = wrap to step 0 after cfg_last, 0 = one-shot; sampled on accepted start.
REQ-010 SHALL have port start, in, 1: single-cycle run request.
REQ-011 SHALL have port stop, in, 1: single-cycle abort request.
REQ-012 SHALL have port duty_out, out, 8: duty fed to the PWM core.
REQ-013 SHALL have port bits_out, out, 3: resolution fed to the PWM core.
REQ-014 SHALL have port step_idx, out, 3: active step index.
REQ-015 SHALL have port busy, out, 1: high in RUN.
REQ-016 SHALL have port done, out, 1: one-cycle pulse on one-shot completion.

Function
REQ-017 SHALL implement two states: IDLE and RUN; all outputs registered.
REQ-018 SHALL write cfg_wdata to table[cfg_addr] on any edge with cfg_we=1, in both states.
REQ-019 SHALL accept start only in IDLE with stop=0. At that edge: latch cfg_* into shadow registers, enter RUN, duty_out=table[0], step_idx=0, bits_out=cfg_bits, clear period counter pcnt and hold counter hcnt.
REQ-020 SHALL ignore start in RUN.
REQ-021 SHALL, in RUN, count pcnt 0..2**bits_r inclusive, then wrap to 0; one PWM period = 2**bits_r+1 cycles, matching the core's counter.
REQ-022 SHALL compute pcnt and the 2**bits_r compare at 9 bits, so bits_r=7 yields a period of 129 cycles with no overflow.
REQ-023 SHALL treat hold_eff = max(hold_r,1); hold_r=0 behaves as 1.
REQ-024 SHALL end a step when pcnt==2**bits_r and hcnt==hold_eff-1; otherwise, at pcnt wrap, increment hcnt.
REQ-025 SHALL act at step end as follows: if step_idx<last_r, load table[step_idx+1] into duty_out, increment step_idx, clear hcnt.
REQ-026 SHALL act at step end as follows: if step_idx==last_r and loop_r=1, load table[0] and set step_idx=0.
REQ-027 SHALL act at step end as follows: if step_idx==last_r and loop_r=0, go to IDLE, set done=1 for exactly one cycle, duty_out=0, busy=0.
REQ-028 SHALL sample the table only at step load; a write to the active entry takes effect at that entry's next load.
REQ-029 SHALL hold bits_out constant for the whole run, so the core counter is never reset mid-run.
REQ-030 SHALL, on stop in RUN, go to IDLE at that edge with duty_out=0, busy=0, step_idx=0, and no done pulse.
REQ-031 SHALL let stop win when start and stop are asserted together.
REQ-032 SHALL, in IDLE, keep duty_out=0 and bits_out at the last run's value.

Reset
REQ-033 SHALL, on any edge with rst_n=0 (including mid-run): state=IDLE; duty_out=0, bits_out=0, step_idx=0, busy=0, done=0; pcnt, hcnt and shadow registers=0; all 8 table entries=0.
REQ-034 SHALL give rst_n priority over start, stop and cfg_we.

Verification
REQ-035 SHALL cover: rst_n low 2 cycles mid-run -> all outputs 0, table reads 0 on the next run.
REQ-036 SHALL cover: table {10,20,30}, bits=2, hold=1, last=2, loop=0, start at edge 0 -> duty 10 edges 0-4, 20 edges 5-9, 30 edges 10-14; edge 15 done=1, duty 0, busy 0.
REQ-037 SHALL cover: the same run with loop=1 -> duty 10 again at edge 15, busy stays 1, no done.
REQ-038 SHALL cover: stop at edge 7 of that run -> edge 7 busy 0, duty 0, step_idx 0, no done pulse.
REQ-039 SHALL cover: start+stop same cycle in IDLE -> stays IDLE; start during RUN -> no restart, timing unchanged.
REQ-040 SHALL cover: bits=0, hold=0, last=0, loop=0 -> step lasts 2 cycles, done at edge 2; bits=7, hold=2 -> step lasts 258 cycles.
